fifo_status: RTL and testbench

//   Status stage of the 16-entry FIFO. Consumes the write and read pointers and the qualified

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_status_if.sv | 25 ++
 rtl/fifo_sat_cnt.sv | 13 +
 rtl/fifo_status.sv | 40 ++++
 tb/tb_fifo_status.sv | 113 +++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing and pointer type for the 16-entry FIFO pointer and status stages
package fifo_pkg;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam int CNT_W = 8;
  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/fifo_status_if.sv
// fifo_status_if: pointers/strobes in, flags/counters out; peak_fill exists only with FIFO_STATUS_PEAK_EN
interface fifo_status_if;
  import fifo_pkg::*;
  ptr_t wptr, rptr, fill_cnt;
  logic wr, rd, clr_err;
  logic fifo_full, fifo_empty, fifo_afull, fifo_aempty;
  logic fifo_overflow, fifo_underflow, ptr_err;
  logic [CNT_W-1:0] ovf_cnt, unf_cnt;
`ifdef FIFO_STATUS_PEAK_EN
  ptr_t peak_fill;
  modport master (output wptr, rptr, wr, rd, clr_err,
                  input fifo_full, fifo_empty, fifo_afull, fifo_aempty, fill_cnt,
                  fifo_overflow, fifo_underflow, ptr_err, ovf_cnt, unf_cnt, peak_fill);
  modport slave (input wptr, rptr, wr, rd, clr_err,
                 output fifo_full, fifo_empty, fifo_afull, fifo_aempty, fill_cnt,
                 fifo_overflow, fifo_underflow, ptr_err, ovf_cnt, unf_cnt, peak_fill);
`else
  modport master (output wptr, rptr, wr, rd, clr_err,
                  input fifo_full, fifo_empty, fifo_afull, fifo_aempty, fill_cnt,
                  fifo_overflow, fifo_underflow, ptr_err, ovf_cnt, unf_cnt);
  modport slave (input wptr, rptr, wr, rd, clr_err,
                 output fifo_full, fifo_empty, fifo_afull, fifo_aempty, fill_cnt,
                 fifo_overflow, fifo_underflow, ptr_err, ovf_cnt, unf_cnt);
`endif
endinterface

// File: rtl/fifo_sat_cnt.sv
// fifo_sat_cnt: saturating event counter; an increment in the clear cycle leaves the count at 1
module fifo_sat_cnt
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : clr ? (inc ? CNT_W'(1) : '0) : (inc && q != '1) ? q + 1'b1 : q;
endmodule

// File: rtl/fifo_status.sv
// fifo_status: zero-latency FIFO flags plus sticky over/underflow tracking; FIFO_STATUS_PEAK_EN adds peak_fill
module fifo_status
  import fifo_pkg::*;
#(
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 4
) (
  input logic         clk,
  input logic         rst,
  fifo_status_if.slave s
);
  ptr_t fill;
  logic ovf_ev, unf_ev;
  assign fill = s.wptr - s.rptr;
  // Flags stay combinational: the pointer stages act on them in the same cycle
  assign s.fill_cnt    = fill;
  assign s.fifo_empty  = s.wptr == s.rptr;
  assign s.fifo_full   = (s.wptr[ADDR_W] != s.rptr[ADDR_W]) && (s.wptr[ADDR_W-1:0] == s.rptr[ADDR_W-1:0]);
  assign s.fifo_afull  = fill >= PTR_W'(AFULL_TH);
  assign s.fifo_aempty = fill <= PTR_W'(AEMPTY_TH);
  assign ovf_ev = s.wr & s.fifo_full;
  assign unf_ev = s.rd & s.fifo_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      s.fifo_overflow  <= 1'b0;
      s.fifo_underflow <= 1'b0;
      s.ptr_err        <= 1'b0;
    end else begin
      s.fifo_overflow  <= ovf_ev | (s.fifo_overflow & ~s.clr_err);
      s.fifo_underflow <= unf_ev | (s.fifo_underflow & ~s.clr_err);
      s.ptr_err        <= (fill > PTR_W'(DEPTH)) | (s.ptr_err & ~s.clr_err);
    end
  end
  fifo_sat_cnt u_ovf_cnt (.clk(clk), .rst(rst), .inc(ovf_ev), .clr(s.clr_err), .q(s.ovf_cnt));
  fifo_sat_cnt u_unf_cnt (.clk(clk), .rst(rst), .inc(unf_ev), .clr(s.clr_err), .q(s.unf_cnt));
`ifdef FIFO_STATUS_PEAK_EN
  always_ff @(posedge clk)
    s.peak_fill <= rst ? '0 : s.clr_err ? fill : (fill > s.peak_fill ? fill : s.peak_fill);
`endif
endmodule

// File: tb/tb_fifo_status.sv
// tb_fifo_status: directed and randomized checks of fifo_status against an arithmetic occupancy model
module tb_fifo_status;
  import fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_status_if bus();
  fifo_status dut (.clk(clk), .rst(rst), .s(bus.slave));
  int n_cmp = 0;
  int n_err = 0;
  bit m_of, m_uf, m_pe;
  int m_ovf, m_unf, m_peak;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int w, input int r, input bit wr_i, input bit rd_i, input bit clr_i, input bit rst_i);
    int fill;
    bit ev_o, ev_u;
    @(negedge clk);
    bus.wptr = PTR_W'(w);
    bus.rptr = PTR_W'(r);
    bus.wr = wr_i;
    bus.rd = rd_i;
    bus.clr_err = clr_i;
    rst = rst_i;
    fill = (w - r + 32) % 32;
    #1;
    check("fill_cnt", bus.fill_cnt, fill);
    check("full", bus.fifo_full, fill == DEPTH);
    check("empty", bus.fifo_empty, fill == 0);
    check("afull", bus.fifo_afull, fill >= 12);
    check("aempty", bus.fifo_aempty, fill <= 4);
    ev_o = wr_i && fill == DEPTH;
    ev_u = rd_i && fill == 0;
    if (rst_i) begin
      {m_of, m_uf, m_pe} = '0;
      m_ovf = 0; m_unf = 0; m_peak = 0;
    end else begin
      if (ev_o) begin m_of = 1; m_ovf = clr_i ? 1 : (m_ovf == 255 ? 255 : m_ovf + 1); end
      else if (clr_i) begin m_of = 0; m_ovf = 0; end
      if (ev_u) begin m_uf = 1; m_unf = clr_i ? 1 : (m_unf == 255 ? 255 : m_unf + 1); end
      else if (clr_i) begin m_uf = 0; m_unf = 0; end
      if (fill > DEPTH) m_pe = 1;
      else if (clr_i) m_pe = 0;
      m_peak = clr_i ? fill : (fill > m_peak ? fill : m_peak);
    end
    @(posedge clk);
    #1;
    check("overflow", bus.fifo_overflow, m_of);
    check("underflow", bus.fifo_underflow, m_uf);
    check("ptr_err", bus.ptr_err, m_pe);
    check("ovf_cnt", bus.ovf_cnt, m_ovf);
    check("unf_cnt", bus.unf_cnt, m_unf);
`ifdef FIFO_STATUS_PEAK_EN
    check("peak_fill", bus.peak_fill, m_peak);
`endif
  endtask
  initial begin
    int r, f;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_ovf_cnt", bus.ovf_cnt, 0);
    step(16, 0, 0, 0, 0, 0);
    check("full16", bus.fifo_full, 1);
    step(12, 0, 0, 0, 0, 0);
    check("afull12", bus.fifo_afull, 1);
    step(4, 0, 0, 0, 0, 0);
    check("aempty4", bus.fifo_aempty, 1);
    step(3, 29, 0, 0, 0, 0);
    check("wrap_fill", bus.fill_cnt, 6);
    step(31, 31, 0, 0, 0, 0);
    check("wrap_empty", bus.fifo_empty, 1);
    for (int i = 1; i <= 3; i++) begin
      step(20, 4, 1, 1, 0, 0);
      check("ovf_seq", bus.ovf_cnt, i);
    end
    step(20, 4, 0, 0, 1, 0);
    check("ovf_clr", bus.fifo_overflow, 0);
    step(7, 7, 0, 1, 1, 0);
    check("unf_set_wins", bus.unf_cnt, 1);
    repeat (300) step(9, 9, 0, 1, 0, 0);
    check("unf_sat", bus.unf_cnt, 255);
`ifdef FIFO_STATUS_PEAK_EN
    step(0, 0, 0, 0, 1, 0);
    step(9, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    check("peak9", bus.peak_fill, 9);
    step(2, 0, 0, 0, 1, 0);
    check("peak_clr", bus.peak_fill, 2);
`endif
    step(20, 0, 0, 0, 0, 0);
    check("ptr_err", bus.ptr_err, 1);
    step(5, 5, 1, 1, 1, 1);
    check("rst_mid", bus.fifo_underflow, 0);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 31);
      case ($urandom_range(0, 5))
        0: f = 0;
        1: f = DEPTH;
        2: f = $urandom_range(17, 31);
        default: f = $urandom_range(0, DEPTH);
      endcase
      step((r + f) % 32, r, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
